// File: rtl/array_pkg.sv
// Shared parameters and FSM state encoding for the array shift-down engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package array_pkg;

   localparam int MEMORY_ELEMENT_WIDTH = 12;
   localparam int N_AREA               = 4;
   localparam int N_ARRAYS             = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/array_heap.sv
// Heap storage (NArrays areas of NArea elements) plus per-array length table.
// Latency: writes commit on the clock edge; both read ports are combinational.
// Backpressure: none; out-of-range writes are dropped, out-of-range reads return 0.
module array_heap
   import array_pkg::*;
#(
   parameter int MemoryElementWidth = MEMORY_ELEMENT_WIDTH,
   parameter int NArea              = N_AREA,
   parameter int NArrays            = N_ARRAYS
) (
   input  logic                          clock,
   input  logic                          reset,
   // single element write port; wr_grow extends the array length to cover the slot
   input  logic                          wr_en,
   input  logic                          wr_grow,
   input  logic [MemoryElementWidth-1:0] wr_array,
   input  logic [MemoryElementWidth-1:0] wr_index,
   input  logic [MemoryElementWidth-1:0] wr_data,
   // length decrement for the array that just lost an element
   input  logic                          shrink_en,
   input  logic [MemoryElementWidth-1:0] shrink_array,
   // read port a (external)
   input  logic [MemoryElementWidth-1:0] a_array,
   input  logic [MemoryElementWidth-1:0] a_index,
   output logic [MemoryElementWidth-1:0] a_data,
   output logic [MemoryElementWidth-1:0] a_length,
   // read port b (shift engine)
   input  logic [MemoryElementWidth-1:0] b_array,
   input  logic [MemoryElementWidth-1:0] b_index,
   output logic [MemoryElementWidth-1:0] b_data,
   output logic [MemoryElementWidth-1:0] b_length
);

   localparam int Depth = NArea * NArrays;
   localparam int AddrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int SelW  = (NArrays > 1) ? $clog2(NArrays) : 1;
   localparam logic [MemoryElementWidth-1:0] AREA   = MemoryElementWidth'(NArea);
   localparam logic [MemoryElementWidth-1:0] ARRAYS = MemoryElementWidth'(NArrays);

   logic [MemoryElementWidth-1:0] mem [Depth];
   logic [MemoryElementWidth-1:0] len [NArrays];

   // an index never wraps into the neighbouring area: both coordinates must be in range
   function automatic logic in_range(input logic [MemoryElementWidth-1:0] arr,
                                     input logic [MemoryElementWidth-1:0] idx);
      return (arr < ARRAYS) && (idx < AREA);
   endfunction

   function automatic logic [AddrW-1:0] addr_of(input logic [MemoryElementWidth-1:0] arr,
                                                input logic [MemoryElementWidth-1:0] idx);
      logic [MemoryElementWidth-1:0] flat;
      flat = arr * AREA + idx;
      return flat[AddrW-1:0];
   endfunction

   // element storage: deliberately not reset, contents are undefined until written
   always_ff @(posedge clock) begin
      if (wr_en && in_range(wr_array, wr_index))
         mem[addr_of(wr_array, wr_index)] <= wr_data;
   end

   // length table: grows to max(length, index+1) on external writes, shrinks by one on removal
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < NArrays; k++)
            len[k] <= '0;
      end else begin
         if (wr_en && wr_grow && in_range(wr_array, wr_index) &&
             (wr_index >= len[wr_array[SelW-1:0]]))
            len[wr_array[SelW-1:0]] <= wr_index + MemoryElementWidth'(1);
         if (shrink_en && (shrink_array < ARRAYS) && (len[shrink_array[SelW-1:0]] != '0))
            len[shrink_array[SelW-1:0]] <= len[shrink_array[SelW-1:0]] - MemoryElementWidth'(1);
      end
   end

   // combinational reads of committed state
   always_comb begin
      a_data   = in_range(a_array, a_index) ? mem[addr_of(a_array, a_index)] : '0;
      a_length = (a_array < ARRAYS) ? len[a_array[SelW-1:0]] : '0;
      b_data   = in_range(b_array, b_index) ? mem[addr_of(b_array, b_index)] : '0;
      b_length = (b_array < ARRAYS) ? len[b_array[SelW-1:0]] : '0;
   end

endmodule

// File: rtl/array_shift_down.sv
// Removes one element from an array on the heap, closing the gap one move per cycle.
// Latency: done 2+(length-1-pos) edges after the start edge; an invalid start is answered by that edge.
// Backpressure: start and element writes are ignored unless the engine is idle.
module array_shift_down
   import array_pkg::*;
#(
   parameter int MemoryElementWidth = MEMORY_ELEMENT_WIDTH,
   parameter int NArea              = N_AREA,
   parameter int NArrays            = N_ARRAYS
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          wr_en,
   input  logic [MemoryElementWidth-1:0] wr_array,
   input  logic [MemoryElementWidth-1:0] wr_index,
   input  logic [MemoryElementWidth-1:0] wr_data,
   input  logic                          start,
   input  logic [MemoryElementWidth-1:0] op_array,
   input  logic [MemoryElementWidth-1:0] op_pos,
   output logic                          busy,
   output logic                          done,
   output logic                          error,
   output logic [MemoryElementWidth-1:0] removed,
   input  logic [MemoryElementWidth-1:0] rd_array,
   input  logic [MemoryElementWidth-1:0] rd_index,
   output logic [MemoryElementWidth-1:0] rd_data,
   output logic [MemoryElementWidth-1:0] rd_length
);

   localparam logic [MemoryElementWidth-1:0] ARRAYS = MemoryElementWidth'(NArrays);

   state_t state, state_nxt;

   logic [MemoryElementWidth-1:0] arr_q, cur_q, removed_q, cur_inc;
   logic                          err_q;
   logic [MemoryElementWidth-1:0] b_array, b_index, b_data, b_length;
   logic [MemoryElementWidth-1:0] h_array, h_index, h_data;
   logic                          h_wr_en, h_grow, shrink_en;
   logic                          start_bad, more;

   assign cur_inc = cur_q + MemoryElementWidth'(1);

   // engine read port: the requested array while idle (for the length check), the latched one after;
   // LOAD fetches the victim, SHIFT fetches the element above the cursor
   always_comb begin
      b_array   = (state == IDLE) ? op_array : arr_q;
      b_index   = (state == LOAD) ? cur_q : cur_inc;
      start_bad = (op_array >= ARRAYS) || (op_pos >= b_length);
      more      = (cur_inc < b_length);
   end

   // single heap write port shared between external writes (idle only) and shift moves
   always_comb begin
      h_wr_en   = 1'b0;
      h_grow    = 1'b0;
      h_array   = arr_q;
      h_index   = cur_q;
      h_data    = b_data;
      shrink_en = 1'b0;
      if (state == IDLE) begin
         h_wr_en = wr_en;
         h_grow  = 1'b1;
         h_array = wr_array;
         h_index = wr_index;
         h_data  = wr_data;
      end else if (state == SHIFT) begin
         h_wr_en   = more;
         shrink_en = !more;
      end
   end

   array_heap #(
      .MemoryElementWidth (MemoryElementWidth),
      .NArea              (NArea),
      .NArrays            (NArrays)
   ) u_heap (
      .clock        (clock),
      .reset        (reset),
      .wr_en        (h_wr_en),
      .wr_grow      (h_grow),
      .wr_array     (h_array),
      .wr_index     (h_index),
      .wr_data      (h_data),
      .shrink_en    (shrink_en),
      .shrink_array (arr_q),
      .a_array      (rd_array),
      .a_index      (rd_index),
      .a_data       (rd_data),
      .a_length     (rd_length),
      .b_array      (b_array),
      .b_index      (b_index),
      .b_data       (b_data),
      .b_length     (b_length)
   );

   // state register; reset aborts any shift in progress
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = start_bad ? DONE : LOAD;
         LOAD:    state_nxt = SHIFT;
         SHIFT:   if (!more) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // operands captured at start, victim latched in LOAD, cursor advanced per move
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         arr_q     <= '0;
         cur_q     <= '0;
         removed_q <= '0;
         err_q     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (start) begin
               arr_q <= op_array;
               cur_q <= op_pos;
               err_q <= start_bad;
            end
            LOAD:    removed_q <= b_data;
            SHIFT:   if (more) cur_q <= cur_inc;
            default: ;
         endcase
      end
   end

   // outputs decoded from state; error is only meaningful alongside done
   always_comb begin
      busy    = (state == LOAD) || (state == SHIFT);
      done    = (state == DONE);
      error   = (state == DONE) && err_q;
      removed = removed_q;
   end

endmodule

// File: tb/tb_array_shift_down.sv
// Directed bench for array_shift_down with a per-cycle reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_array_shift_down;

   localparam int W = 12;

   logic         clock = 1'b0;
   logic         reset;
   logic         wr_en = 1'b0, start = 1'b0;
   logic [W-1:0] wr_array = '0, wr_index = '0, wr_data = '0;
   logic [W-1:0] op_array = '0, op_pos = '0, rd_array = '0, rd_index = '0;
   logic         busy, done, error;
   logic [W-1:0] removed, rd_data, rd_length;

   int n_vec = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   always #5 clock = ~clock;

   array_shift_down #(.MemoryElementWidth(W), .NArea(4), .NArrays(2)) dut (
      .clock(clock), .reset(reset),
      .wr_en(wr_en), .wr_array(wr_array), .wr_index(wr_index), .wr_data(wr_data),
      .start(start), .op_array(op_array), .op_pos(op_pos),
      .busy(busy), .done(done), .error(error), .removed(removed),
      .rd_array(rd_array), .rd_index(rd_index), .rd_data(rd_data), .rd_length(rd_length)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Whole-operation view: a valid start makes the engine busy for a fixed number of edges
   // derived from length and position, then the element is removed from the array in one go.
   int m_heap [2][4];
   int m_len  [2];
   bit m_busy, m_done, m_err;
   int m_removed, m_cnt, m_total, m_arr, m_pos;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_busy = 0; m_done = 0; m_err = 0; m_removed = 0;
         m_len[0] = 0; m_len[1] = 0;
      end else if (m_done) begin
         m_done = 0;
      end else if (m_busy) begin
         m_cnt--;
         if (m_cnt == m_total - 1) m_removed = m_heap[m_arr][m_pos];
         if (m_cnt == 0) begin
            for (int k = m_pos; k < m_len[m_arr] - 1; k++)
               m_heap[m_arr][k] = m_heap[m_arr][k+1];
            m_len[m_arr]--;
            m_busy = 0; m_done = 1; m_err = 0;
         end
      end else begin
         if (start) begin
            if (op_array >= 2 || int'(op_pos) >= m_len[op_array[0]]) begin
               m_done = 1; m_err = 1;
            end else begin
               m_busy  = 1;
               m_arr   = int'(op_array);
               m_pos   = int'(op_pos);
               m_total = 2 + (m_len[m_arr] - 1 - m_pos);
               m_cnt   = m_total;
            end
         end
         if (wr_en && wr_array < 2 && wr_index < 4) begin
            m_heap[wr_array[0]][wr_index[1:0]] = int'(wr_data);
            if (int'(wr_index) + 1 > m_len[wr_array[0]]) m_len[wr_array[0]] = int'(wr_index) + 1;
         end
      end
   end

   // per-cycle comparison against the model
   always @(negedge clock) begin
      if (chk_en && reset) begin
         int exp_len;
         check("busy", busy, m_busy);
         check("done", done, m_done);
         if (m_done) check("error", error, m_err);
         check("removed", removed, m_removed);
         exp_len = (rd_array < 2) ? m_len[rd_array[0]] : 0;
         check("rd_length", rd_length, exp_len);
         if (!m_busy && rd_array < 2 && int'(rd_index) < exp_len)
            check("rd_data", rd_data, m_heap[rd_array[0]][rd_index[1:0]]);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input int a, input int i, input int d);
      wr_en = 1; wr_array = W'(a); wr_index = W'(i); wr_data = W'(d);
      step();
      wr_en = 0;
   endtask

   task automatic rd_chk(input string tag, input int a, input int i, input int exp);
      rd_array = W'(a); rd_index = W'(i);
      #1;
      check(tag, rd_data, exp);
   endtask

   task automatic len_chk(input string tag, input int a, input int exp);
      rd_array = W'(a); rd_index = '0;
      #1;
      check(tag, rd_length, exp);
   endtask

   // exp_lat counts edges after the edge that samples start; an error start is
   // answered by that sampling edge itself, i.e. 0 here (one edge after start is raised)
   task automatic run_op(input string tag, input int a, input int p,
                         input int exp_lat, input bit exp_err, input bit inject);
      int edges;
      op_array = W'(a); op_pos = W'(p); start = 1;
      step();
      start = 0; op_array = W'(a ^ 1); op_pos = '0;
      edges = 0;
      while (!done && edges < 40) begin
         if (inject && edges == 0) begin
            wr_en = 1; wr_array = 1; wr_index = 0; wr_data = 55;
            start = 1; op_array = 1; op_pos = 0;
         end
         step();
         wr_en = 0; start = 0;
         edges++;
      end
      check({tag, " latency"}, edges, exp_lat);
      check({tag, " error"}, error, exp_err);
      step();
      check({tag, " done one cycle"}, done, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1;
      #1 reset = 0;
      repeat (2) step();
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset error", error, 0);
      check("reset removed", removed, 0);
      len_chk("reset len0", 0, 0);
      len_chk("reset len1", 1, 0);
      reset = 1;
      chk_en = 1;
      step();

      // fill arrays; out-of-range writes must be dropped
      wr(1, 0, 0); wr(1, 1, 1); wr(1, 2, 99); wr(1, 3, 2);
      wr(0, 0, 5); wr(0, 1, 6); wr(0, 2, 7);
      wr(2, 0, 77); wr(0, 4, 77);
      len_chk("fill len1", 1, 4);
      len_chk("fill len0", 0, 3);
      rd_chk("no wrap a1[0]", 1, 0, 0);

      // remove middle element of array 1
      run_op("r032", 1, 2, 3, 0, 0);
      check("r032 removed", removed, 99);
      rd_chk("r032 a1[0]", 1, 0, 0);
      rd_chk("r032 a1[1]", 1, 1, 1);
      rd_chk("r032 a1[2]", 1, 2, 2);
      len_chk("r032 len", 1, 3);

      // remove head of array 0
      run_op("r033", 0, 0, 4, 0, 0);
      check("r033 removed", removed, 5);
      rd_chk("r033 a0[0]", 0, 0, 6);
      rd_chk("r033 a0[1]", 0, 1, 7);
      len_chk("r033 len", 0, 2);

      // remove tail: no moves
      wr(0, 0, 5); wr(0, 1, 6); wr(0, 2, 7);
      run_op("r034", 0, 2, 2, 0, 0);
      check("r034 removed", removed, 7);
      len_chk("r034 len", 0, 2);

      // position past the end
      run_op("r035", 0, 2, 0, 1, 0);
      check("r035 removed", removed, 7);
      len_chk("r035 len", 0, 2);
      rd_chk("r035 a0[0]", 0, 0, 5);
      rd_chk("r035 a0[1]", 0, 1, 6);

      // write and restart while busy are ignored
      wr(1, 0, 0); wr(1, 1, 1); wr(1, 2, 99); wr(1, 3, 2);
      run_op("r037", 1, 2, 3, 0, 1);
      check("r037 removed", removed, 99);
      rd_chk("r037 a1[0]", 1, 0, 0);
      rd_chk("r037 a1[1]", 1, 1, 1);
      rd_chk("r037 a1[2]", 1, 2, 2);
      len_chk("r037 len", 1, 3);

      // reset in the middle of a shift
      wr(0, 0, 10); wr(0, 1, 11); wr(0, 2, 12); wr(0, 3, 13);
      op_array = 0; op_pos = 0; start = 1;
      step();
      start = 0;
      step();
      step();
      check("r036 busy mid-shift", busy, 1);
      #2 reset = 0;
      #1;
      check("r036 busy", busy, 0);
      check("r036 done", done, 0);
      check("r036 removed", removed, 0);
      len_chk("r036 len0", 0, 0);
      len_chk("r036 len1", 1, 0);
      step();
      reset = 1;
      step();
      run_op("r036 post", 0, 0, 0, 1, 0);
      check("r036 post removed", removed, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/array_shift_down.md
ARRAY_SHIFT_DOWN -- requirements
Module: array_shift_down

Interface
REQ-001 SHALL have parameter MemoryElementWidth, default 12, width of each heap element and of every data and index port.
REQ-002 SHALL have parameter NArea, default 4, elements per array area on the heap.
REQ-003 SHALL have parameter NArrays, default 2, number of arrays; heap depth is NArea*NArrays.
REQ-004 SHALL have port clock, input, 1, single clock; all state changes on posedge clock.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports wr_en (input, 1), wr_array, wr_index, wr_data (inputs, MemoryElementWidth): element write, i.e. heap[wr_array*NArea+wr_index] = wr_data.
REQ-007 SHALL have ports start (input, 1), op_array and op_pos (inputs, MemoryElementWidth): shiftDown request that removes element op_pos of array op_array.
REQ-008 SHALL have ports busy, done and error (outputs, 1), and removed (output, MemoryElementWidth), the value taken out.
REQ-009 SHALL have ports rd_array and rd_index (inputs, MemoryElementWidth), and rd_data and rd_length (outputs, MemoryElementWidth): combinational element and length read.

Function
REQ-010 wr_en in IDLE SHALL write the element and set length[wr_array] = max(length, wr_index+1).
REQ-011 wr_en with wr_array >= NArrays or wr_index >= NArea SHALL be ignored.
REQ-012 wr_en while busy SHALL be ignored.
REQ-013 FSM states SHALL be IDLE, LOAD, SHIFT and DONE; busy SHALL be high in LOAD and SHIFT.
REQ-014 IDLE SHALL go to LOAD on start; start SHALL be ignored when not in IDLE.
REQ-015 IDLE with start and (op_pos >= length[op_array] or op_array >= NArrays) SHALL go straight to DONE with error=1, leaving heap, lengths and removed unchanged.
REQ-016 LOAD SHALL latch removed = heap[op_array*NArea+op_pos], set cursor i = op_pos, then go to SHIFT.
REQ-017 SHIFT SHALL perform exactly one move per cycle, heap[base+i] = heap[base+i+1] then i = i+1, while i+1 < length.
REQ-018 SHIFT SHALL go to DONE when i+1 >= length; on that exit length[op_array] SHALL decrement by 1.
REQ-019 SHIFT SHALL perform no moves when op_pos = length-1.
REQ-020 DONE SHALL hold done high for exactly one cycle, then go to IDLE; error SHALL be valid only while done is high.
REQ-021 Latency: done SHALL be high in the cycle 2+(length-1-op_pos) edges after the edge sampling a valid start, or 1 edge after for an error start.
REQ-022 removed SHALL hold its value until the next valid LOAD.
REQ-023 op_array and op_pos SHALL be captured at start; later input changes SHALL have no effect.
REQ-024 Heap slots beyond the new length SHALL keep stale data; only length defines contents.
REQ-025 Index arithmetic SHALL be unsigned at MemoryElementWidth, with no wrap inside an area.
REQ-026 rd_data and rd_length SHALL reflect committed state, including mid-shift contents.

Reset
REQ-027 reset low SHALL force IDLE immediately, including mid-operation, aborting any shift.
REQ-028 reset low SHALL clear busy, done, error, removed and every length to 0.
REQ-029 Heap contents SHALL NOT be reset and SHALL be treated as undefined after reset.

Structure
REQ-030 Parameter defaults and the state enum SHALL reside in shared package array_pkg.
REQ-031 Heap storage and length table SHALL be one sub-module, array_heap, with one write port and two read ports; the FSM SHALL reside in array_shift_down.

Verification
REQ-032 Write array 1 = [0,1,99,2], then start pos=2 -> removed=99, array=[0,1,2], length=3, done 3 edges after start, error=0.
REQ-033 Write array 0 = [5,6,7], then start pos=0 -> removed=5, array=[6,7], length=2, done after 4 edges.
REQ-034 Array 0 length 3, start pos=2 -> removed=7, no moves, length=2, done after 2 edges.
REQ-035 Array 0 length 2, start pos=2 -> done and error after 1 edge; heap, length and removed unchanged.
REQ-036 Start pos=0 on a length-4 array, drive reset low during SHIFT -> immediate IDLE, busy=0, all lengths 0; a later start on length 0 -> error.
REQ-037 wr_en and a second start while busy -> both ignored; result identical to REQ-032.
